dcache_wb_buffer: RTL and testbench

DCACHE_WB_BUFFER -- requirements
Module: dcache_wb_buffer

---
 rtl/dcache_wb_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_dcache_wb_buffer.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_wb_buffer.sv
// Data-cache write-back buffer: queues evicted 256-bit lines in a small FIFO
// and drains them to the cache-AXI bridge, while refills run in parallel unless they hit a buffered line.
module dcache_wb_buffer #(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_req,
    input  logic [31:0]  wr_addr,
    input  logic [255:0] wr_data,
    output logic         wr_rdy,
    input  logic         rd_req,
    input  logic [31:0]  rd_addr,
    output logic         rd_rdy,
    output logic         ret_valid,
    output logic [255:0] ret_data,
    output logic         data_wen_o,
    output logic [31:0]  data_awaddr_o,
    output logic [255:0] data_wdata_o,
    input  logic         data_bvalid_i,
    output logic         data_ren_o,
    output logic [31:0]  data_araddr_o,
    input  logic         data_rvalid_i,
    input  logic [255:0] data_rdata_i
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic {
        W_IDLE,
        W_BUSY
    } w_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RET
    } r_state_t;

    // ------------------------------------------------------------------
    // Storage and FIFO bookkeeping
    // ------------------------------------------------------------------
    logic [26:0]      addr_mem [DEPTH];
    logic [255:0]     data_mem [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] entry_match;
    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [CNT_W-1:0] count_reg;

    w_state_t w_state_reg;
    w_state_t w_state_next;
    r_state_t r_state_reg;
    r_state_t r_state_next;

    logic push;
    logic pop;
    logic hit;
    logic rd_accept;
    logic drain_start;
    logic unused_low_bits;

    // Line offset bits carry no meaning for a whole-line buffer
    assign unused_low_bits = ^{wr_addr[4:0], rd_addr[4:0]};

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign wr_rdy      = (count_reg != FULL_CNT);
    assign push        = wr_req && wr_rdy;
    assign pop         = (w_state_reg == W_BUSY) && data_bvalid_i;
    assign drain_start = (w_state_reg == W_IDLE) && (count_reg != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail_reg] <= wr_addr[31:5];
            data_mem[tail_reg] <= wr_data;
        end
    end

    // The entry being drained keeps its valid bit until bvalid pops it,
    // so a refill of that line keeps stalling until memory is up to date.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign valid_next[gi] =
                (push && (tail_reg == PTR_W'(gi))) ? 1'b1 :
                (pop  && (head_reg == PTR_W'(gi))) ? 1'b0 :
                valid_reg[gi];
            assign entry_match[gi] = valid_reg[gi] && (addr_mem[gi] == rd_addr[31:5]);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            if (push) begin
                tail_reg <= ptr_inc(tail_reg);
            end
            if (pop) begin
                head_reg <= ptr_inc(head_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // A line entering the buffer this very cycle also counts as a hazard
    assign hit = (|entry_match) || (push && (wr_addr[31:5] == rd_addr[31:5]));

    // ------------------------------------------------------------------
    // Write-drain FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_reg <= W_IDLE;
        end else begin
            w_state_reg <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (count_reg != '0) begin
                    w_state_next = W_BUSY;
                end
            end
            W_BUSY: begin
                if (data_bvalid_i) begin
                    w_state_next = W_IDLE;
                end
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    always_comb begin
        data_wen_o = (w_state_reg == W_BUSY);
    end

    // Head entry is captured once per drain and held until the next drain starts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_awaddr_o <= '0;
            data_wdata_o  <= '0;
        end else if (drain_start) begin
            data_awaddr_o <= {addr_mem[head_reg], 5'b0};
            data_wdata_o  <= data_mem[head_reg];
        end
    end

    // ------------------------------------------------------------------
    // Refill FSM
    // ------------------------------------------------------------------
    assign rd_rdy    = (r_state_reg == R_IDLE) && !hit;
    assign rd_accept = rd_req && rd_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg <= R_IDLE;
        end else begin
            r_state_reg <= r_state_next;
        end
    end

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (rd_accept) begin
                    r_state_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (data_rvalid_i) begin
                    r_state_next = R_RET;
                end
            end
            R_RET:   r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_comb begin
        data_ren_o = (r_state_reg == R_WAIT);
        ret_valid  = (r_state_reg == R_RET);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_araddr_o <= '0;
            ret_data      <= '0;
        end else begin
            if (rd_accept) begin
                data_araddr_o <= {rd_addr[31:5], 5'b0};
            end
            if ((r_state_reg == R_WAIT) && data_rvalid_i) begin
                ret_data <= data_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Scoreboard bench for dcache_wb_buffer: write lines are queued when accepted and
// checked when the bridge sees them; refill lines are queued when returned and checked on ret_valid.
module tb_dcache_wb_buffer;

    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         wr_req = 1'b0;
    logic [31:0]  wr_addr = '0;
    logic [255:0] wr_data = '0;
    logic         wr_rdy;
    logic         rd_req = 1'b0;
    logic [31:0]  rd_addr = '0;
    logic         rd_rdy;
    logic         ret_valid;
    logic [255:0] ret_data;
    logic         data_wen_o;
    logic [31:0]  data_awaddr_o;
    logic [255:0] data_wdata_o;
    logic         data_bvalid_i = 1'b0;
    logic         data_ren_o;
    logic [31:0]  data_araddr_o;
    logic         data_rvalid_i = 1'b0;
    logic [255:0] data_rdata_i = '0;

    typedef struct packed {
        logic [31:0]  addr;
        logic [255:0] data;
    } wr_ent_t;

    wr_ent_t      wq[$];
    logic [255:0] rq[$];
    int n_checks = 0;
    int n_fail   = 0;

    dcache_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_req        (wr_req),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_rdy        (wr_rdy),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .rd_rdy        (rd_rdy),
        .ret_valid     (ret_valid),
        .ret_data      (ret_data),
        .data_wen_o    (data_wen_o),
        .data_awaddr_o (data_awaddr_o),
        .data_wdata_o  (data_wdata_o),
        .data_bvalid_i (data_bvalid_i),
        .data_ren_o    (data_ren_o),
        .data_araddr_o (data_araddr_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] mk_line(input logic [31:0] base);
        logic [255:0] line;
        for (int i = 0; i < 8; i++) begin
            line[i*32 +: 32] = base + 32'(i);
        end
        return line;
    endfunction

    task automatic test_reset;
        #2 rst = 1'b1;
        rd_req = 1'b1;
        #1;
        n_checks++; if (data_wen_o !== 1'b0) begin n_fail++; $display("FAIL rst_wen: got %0b want 0", data_wen_o); end
        n_checks++; if (data_ren_o !== 1'b0) begin n_fail++; $display("FAIL rst_ren: got %0b want 0", data_ren_o); end
        n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ret_valid: got %0b want 0", ret_valid); end
        n_checks++; if (ret_data !== '0) begin n_fail++; $display("FAIL rst_ret_data: got %h want 0", ret_data); end
        n_checks++; if (data_awaddr_o !== '0 || data_wdata_o !== '0 || data_araddr_o !== '0) begin
            n_fail++; $display("FAIL rst_addr_data: aw=%h ar=%h want 0", data_awaddr_o, data_araddr_o);
        end
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_wr_rdy: got %0b want 1", wr_rdy); end
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_rd_rdy: got %0b want 1", rd_rdy); end
        rd_req = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        // stray completions while both FSMs are idle
        data_bvalid_i = 1'b1;
        data_rvalid_i = 1'b1;
        data_rdata_i  = {8{32'h5A5A_5A5A}};
        tick;
        data_bvalid_i = 1'b0;
        data_rvalid_i = 1'b0;
        #1;
        n_checks++; if (data_wen_o !== 1'b0 || wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL idle_bvalid: wen=%0b rdy=%0b want 0/1", data_wen_o, wr_rdy);
        end
        tick;
        n_checks++; if (ret_valid !== 1'b0 || ret_data !== '0) begin
            n_fail++; $display("FAIL idle_rvalid: ret_valid=%0b data=%h want 0/0", ret_valid, ret_data);
        end
        $display("reset: done");
    endtask

    task automatic test_single_write;
        wr_ent_t exp;
        wr_req  = 1'b1;
        wr_addr = 32'h1C00_0047;
        wr_data = mk_line(32'h0);
        #1;
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL single_rdy: got %0b want 1", wr_rdy); end
        wq.push_back({32'h1C00_0040, mk_line(32'h0)});
        tick;
        wr_req = 1'b0;
        n_checks++; if (data_wen_o !== 1'b0) begin n_fail++; $display("FAIL single_wen_early: got %0b want 0", data_wen_o); end
        tick;
        n_checks++; if (data_wen_o !== 1'b1) begin n_fail++; $display("FAIL single_wen_rise: got %0b want 1", data_wen_o); end
        n_checks++;
        if (wq.size() == 0) begin
            n_fail++; $display("FAIL single_sb: got empty scoreboard want entry");
        end else begin
            exp = wq.pop_front();
            if (data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
                n_fail++; $display("FAIL single_line: got %h want %h", data_awaddr_o, exp.addr);
            end
            $display("write drained: addr=%h", data_awaddr_o);
        end
        for (int k = 0; k < 5; k++) begin
            tick;
            n_checks++;
            if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data || wr_rdy !== 1'b1) begin
                n_fail++; $display("FAIL single_hold%0d: wen=%0b addr=%h rdy=%0b want 1/%h/1", k, data_wen_o, data_awaddr_o, wr_rdy, exp.addr);
            end
        end
        data_bvalid_i = 1'b1;
        tick;
        data_bvalid_i = 1'b0;
        #1;
        n_checks++; if (data_wen_o !== 1'b0 || wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL single_pop: wen=%0b rdy=%0b want 0/1", data_wen_o, wr_rdy);
        end
        tick;
        tick;
        n_checks++; if (data_wen_o !== 1'b0) begin n_fail++; $display("FAIL single_empty: wen=%0b want 0", data_wen_o); end
    endtask

    task automatic test_back_to_back;
        wr_ent_t exp;
        logic [31:0] addrs [3];
        addrs[0] = 32'hA000_0100;
        addrs[1] = 32'hB000_0200;
        addrs[2] = 32'hC000_0300;
        for (int i = 0; i < 2; i++) begin
            wr_req  = 1'b1;
            wr_addr = addrs[i];
            wr_data = mk_line(addrs[i]);
            #1;
            n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL b2b_rdy%0d: got %0b want 1", i, wr_rdy); end
            wq.push_back({addrs[i], mk_line(addrs[i])});
            tick;
        end
        wr_addr = addrs[2];
        wr_data = mk_line(addrs[2]);
        #1;
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_full: got %0b want 0", wr_rdy); end
        exp = wq.pop_front();
        n_checks++; if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
            n_fail++; $display("FAIL b2b_drain_a: wen=%0b addr=%h want 1/%h", data_wen_o, data_awaddr_o, exp.addr);
        end
        $display("write drained: addr=%h", data_awaddr_o);
        for (int k = 0; k < 2; k++) begin
            tick;
            n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_stall%0d: rdy=%0b want 0", k, wr_rdy); end
        end
        data_bvalid_i = 1'b1;
        tick;
        data_bvalid_i = 1'b0;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || data_wen_o !== 1'b0) begin
            n_fail++; $display("FAIL b2b_after_pop: rdy=%0b wen=%0b want 1/0", wr_rdy, data_wen_o);
        end
        wq.push_back({addrs[2], mk_line(addrs[2])});
        tick;
        wr_req = 1'b0;
        #1;
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL b2b_c_taken: rdy=%0b want 0", wr_rdy); end
        for (int i = 1; i < 3; i++) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++; $display("FAIL b2b_sb%0d: got empty scoreboard want entry", i);
            end else begin
                exp = wq.pop_front();
                if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
                    n_fail++; $display("FAIL b2b_order%0d: wen=%0b addr=%h want 1/%h", i, data_wen_o, data_awaddr_o, exp.addr);
                end
                $display("write drained: addr=%h", data_awaddr_o);
            end
            data_bvalid_i = 1'b1;
            tick;
            data_bvalid_i = 1'b0;
            #1;
            n_checks++; if (data_wen_o !== 1'b0) begin n_fail++; $display("FAIL b2b_gap%0d: wen=%0b want 0", i, data_wen_o); end
            tick;
        end
        n_checks++; if (data_wen_o !== 1'b0 || wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL b2b_empty: wen=%0b rdy=%0b want 0/1", data_wen_o, wr_rdy);
        end
    endtask

    task automatic test_read_hazard;
        wr_ent_t exp;
        logic [255:0] line;
        wr_req  = 1'b1;
        wr_addr = 32'h8000_0020;
        wr_data = mk_line(32'h8000_0000);
        #1;
        n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL haz_wr_rdy: got %0b want 1", wr_rdy); end
        wq.push_back({32'h8000_0020, mk_line(32'h8000_0000)});
        tick;
        wr_req  = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 32'h8000_0030;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL haz_rd_rdy0: got %0b want 0", rd_rdy); end
        tick;
        exp = wq.pop_front();
        n_checks++; if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
            n_fail++; $display("FAIL haz_drain: wen=%0b addr=%h want 1/%h", data_wen_o, data_awaddr_o, exp.addr);
        end
        $display("write drained: addr=%h", data_awaddr_o);
        for (int k = 0; k < 3; k++) begin
            tick;
            n_checks++; if (rd_rdy !== 1'b0 || data_ren_o !== 1'b0) begin
                n_fail++; $display("FAIL haz_block%0d: rd_rdy=%0b ren=%0b want 0/0", k, rd_rdy, data_ren_o);
            end
        end
        data_bvalid_i = 1'b1;
        #1;
        n_checks++; if (rd_rdy !== 1'b0) begin n_fail++; $display("FAIL haz_pre_pop: rd_rdy=%0b want 0", rd_rdy); end
        tick;
        data_bvalid_i = 1'b0;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL haz_released: rd_rdy=%0b want 1", rd_rdy); end
        tick;
        rd_req = 1'b0;
        n_checks++; if (data_ren_o !== 1'b1 || data_araddr_o !== 32'h8000_0020) begin
            n_fail++; $display("FAIL haz_ren: ren=%0b araddr=%h want 1/80000020", data_ren_o, data_araddr_o);
        end
        line = {8{$urandom()}};
        data_rvalid_i = 1'b1;
        data_rdata_i  = line;
        rq.push_back(line);
        tick;
        data_rvalid_i = 1'b0;
        n_checks++;
        if (rq.size() == 0) begin
            n_fail++; $display("FAIL haz_rq: got empty scoreboard want entry");
        end else begin
            line = rq.pop_front();
            if (ret_valid !== 1'b1 || ret_data !== line) begin
                n_fail++; $display("FAIL haz_ret: valid=%0b data=%h want 1/%h", ret_valid, ret_data, line);
            end
            $display("refill returned: addr=80000020 data=%h", ret_data);
        end
        tick;
        n_checks++; if (ret_valid !== 1'b0) begin n_fail++; $display("FAIL haz_ret_pulse: valid=%0b want 0", ret_valid); end
    endtask

    task automatic test_same_cycle;
        wr_ent_t exp;
        wr_req  = 1'b1;
        wr_addr = 32'h0000_1000;
        wr_data = mk_line(32'h0000_1000);
        rd_req  = 1'b1;
        rd_addr = 32'h0000_1000;
        #1;
        n_checks++; if (wr_rdy !== 1'b1 || rd_rdy !== 1'b0) begin
            n_fail++; $display("FAIL same_rdys: wr_rdy=%0b rd_rdy=%0b want 1/0", wr_rdy, rd_rdy);
        end
        wq.push_back({32'h0000_1000, mk_line(32'h0000_1000)});
        tick;
        wr_req = 1'b0;
        rd_req = 1'b0;
        n_checks++; if (data_ren_o !== 1'b0) begin n_fail++; $display("FAIL same_no_read: ren=%0b want 0", data_ren_o); end
        tick;
        exp = wq.pop_front();
        n_checks++; if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
            n_fail++; $display("FAIL same_drain: wen=%0b addr=%h want 1/%h", data_wen_o, data_awaddr_o, exp.addr);
        end
        $display("write drained: addr=%h", data_awaddr_o);
        data_bvalid_i = 1'b1;
        tick;
        data_bvalid_i = 1'b0;
        tick;
    endtask

    task automatic test_refill;
        logic [255:0] line;
        rd_req  = 1'b1;
        rd_addr = 32'h0000_2000;
        #1;
        n_checks++; if (rd_rdy !== 1'b1) begin n_fail++; $display("FAIL refill_rdy: got %0b want 1", rd_rdy); end
        tick;
        rd_req = 1'b0;
        n_checks++; if (data_ren_o !== 1'b1 || data_araddr_o !== 32'h0000_2000) begin
            n_fail++; $display("FAIL refill_req: ren=%0b araddr=%h want 1/00002000", data_ren_o, data_araddr_o);
        end
        for (int k = 0; k < 9; k++) begin
            tick;
            n_checks++; if (data_ren_o !== 1'b1 || ret_valid !== 1'b0 || rd_rdy !== 1'b0) begin
                n_fail++; $display("FAIL refill_wait%0d: ren=%0b ret_valid=%0b rd_rdy=%0b want 1/0/0", k, data_ren_o, ret_valid, rd_rdy);
            end
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = {8{32'hDEAD_BEEF}};
        rq.push_back({8{32'hDEAD_BEEF}});
        tick;
        data_rvalid_i = 1'b0;
        line = rq.pop_front();
        n_checks++; if (ret_valid !== 1'b1 || ret_data !== line || data_ren_o !== 1'b0) begin
            n_fail++; $display("FAIL refill_ret: valid=%0b ren=%0b data=%h want 1/0/%h", ret_valid, data_ren_o, ret_data, line);
        end
        $display("refill returned: addr=00002000 data=%h", ret_data);
        tick;
        n_checks++; if (ret_valid !== 1'b0 || ret_data !== line) begin
            n_fail++; $display("FAIL refill_hold: valid=%0b data=%h want 0/%h", ret_valid, ret_data, line);
        end
        data_rvalid_i = 1'b1;
        data_rdata_i  = ~line;
        tick;
        data_rvalid_i = 1'b0;
        tick;
        n_checks++; if (ret_valid !== 1'b0 || ret_data !== line || data_ren_o !== 1'b0) begin
            n_fail++; $display("FAIL refill_stray: valid=%0b data=%h want 0/%h", ret_valid, ret_data, line);
        end
    endtask

    task automatic test_reset_mid_write;
        wr_ent_t exp;
        logic [31:0] addrs [2];
        wr_req  = 1'b1;
        wr_addr = 32'h0000_3000;
        wr_data = mk_line(32'h0000_3000);
        wq.push_back({32'h0000_3000, mk_line(32'h0000_3000)});
        tick;
        wr_req = 1'b0;
        tick;
        exp = wq.pop_front();
        n_checks++; if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr) begin
            n_fail++; $display("FAIL rmw_busy: wen=%0b addr=%h want 1/%h", data_wen_o, data_awaddr_o, exp.addr);
        end
        $display("write abandoned by reset: addr=%h", data_awaddr_o);
        #2 rst = 1'b1;
        #1;
        n_checks++; if (data_wen_o !== 1'b0 || data_awaddr_o !== '0 || data_wdata_o !== '0 || wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rmw_async: wen=%0b addr=%h rdy=%0b want 0/0/1", data_wen_o, data_awaddr_o, wr_rdy);
        end
        tick;
        rst = 1'b0;
        tick;
        data_bvalid_i = 1'b1;
        tick;
        data_bvalid_i = 1'b0;
        #1;
        n_checks++; if (data_wen_o !== 1'b0 || wr_rdy !== 1'b1) begin
            n_fail++; $display("FAIL rmw_late_bvalid: wen=%0b rdy=%0b want 0/1", data_wen_o, wr_rdy);
        end
        // two fresh pushes must fill a DEPTH=2 buffer exactly, proving the count restarted at 0
        addrs[0] = 32'h0000_4000;
        addrs[1] = 32'h0000_5000;
        for (int i = 0; i < 2; i++) begin
            tick;
            wr_req  = 1'b1;
            wr_addr = addrs[i];
            wr_data = mk_line(addrs[i]);
            #1;
            n_checks++; if (wr_rdy !== 1'b1) begin n_fail++; $display("FAIL rmw_push%0d: rdy=%0b want 1", i, wr_rdy); end
            wq.push_back({addrs[i], mk_line(addrs[i])});
        end
        tick;
        wr_req = 1'b0;
        #1;
        n_checks++; if (wr_rdy !== 1'b0) begin n_fail++; $display("FAIL rmw_full: rdy=%0b want 0", wr_rdy); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (wq.size() == 0) begin
                n_fail++; $display("FAIL rmw_sb%0d: got empty scoreboard want entry", i);
            end else begin
                exp = wq.pop_front();
                if (data_wen_o !== 1'b1 || data_awaddr_o !== exp.addr || data_wdata_o !== exp.data) begin
                    n_fail++; $display("FAIL rmw_drain%0d: wen=%0b addr=%h want 1/%h", i, data_wen_o, data_awaddr_o, exp.addr);
                end
                $display("write drained: addr=%h", data_awaddr_o);
            end
            data_bvalid_i = 1'b1;
            tick;
            data_bvalid_i = 1'b0;
            tick;
        end
        n_checks++; if (data_wen_o !== 1'b0 || wq.size() != 0) begin
            n_fail++; $display("FAIL rmw_empty: wen=%0b pending=%0d want 0/0", data_wen_o, wq.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_hazard();
        test_same_cycle();
        test_refill();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
